// File: rtl/demux32_buffered_pkg.sv
// -----------------------------------------------------------------------------
// demux32_buffered_pkg
// Shared constants for the buffered 1-to-N write distributor:
//   - default WIDTH / SEL_BITS / NUM_DEST values
//   - queue depth (two entries)
//   - field offsets of the packed queue entry {bcast, data, select}
// -----------------------------------------------------------------------------
package demux32_buffered_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_SEL_BITS = 5;
    localparam int DEF_NUM_DEST = 32;

    localparam int FIFO_DEPTH   = 2;

    // Packed entry layout, LSB first: select, data, then the optional bcast flag.
    localparam int SEL_OFS      = 0;

    function automatic int data_ofs(int sel_bits);
        return sel_bits;
    endfunction

    function automatic int bcast_ofs(int width, int sel_bits);
        return width + sel_bits;
    endfunction

    function automatic int entry_width(int width, int sel_bits, int has_bcast);
        return width + sel_bits + has_bcast;
    endfunction

endpackage

// File: rtl/demux32_buffered_fifo2.sv
// -----------------------------------------------------------------------------
// demux32_buffered_fifo2
// Two-entry queue holding packed {bcast, data, select} entries. The head is
// always slot0 so it can drive the output decode without a read mux.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset (count only)
//   push, push_entry : write request and entry; ignored when full
//   pop              : remove head; ignored when empty
//   not_full         : occupancy below depth (registered state only)
//   head_valid       : queue holds at least one entry
//   head_entry       : oldest entry
// -----------------------------------------------------------------------------
module demux32_buffered_fifo2
    import demux32_buffered_pkg::*;
#(
    parameter int ENTRY_W = 38
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic               not_full,
    output logic               head_valid,
    output logic [ENTRY_W-1:0] head_entry
);

    localparam logic [1:0] DEPTH_L = 2'(FIFO_DEPTH);

    logic [1:0]         count;
    logic [ENTRY_W-1:0] slot0;
    logic [ENTRY_W-1:0] slot1;
    logic               do_push;
    logic               do_pop;

    assign not_full   = (count < DEPTH_L);
    assign head_valid = (count != 2'd0);
    assign head_entry = slot0;

    // A push at full is refused even if the head leaves this same cycle.
    assign do_push = push & not_full;
    assign do_pop  = pop & head_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clock) begin
        if (do_pop) begin
            // Push+pop only happens at count == 1, so the new word becomes head.
            if (do_push) slot0 <= push_entry;
            else         slot0 <= slot1;
        end else if (do_push) begin
            if (count == 2'd0) slot0 <= push_entry;
            else               slot1 <= push_entry;
        end
    end

endmodule

// File: rtl/demux32_buffered.sv
// -----------------------------------------------------------------------------
// demux32_buffered
// Registered 1-to-N write distributor. Words {data, select} are queued in a
// two-entry buffer; the head is presented on a shared data bus with a
// zero-or-one-hot valid per consumer. Heads whose select is out of range are
// discarded with a one-cycle err_drop pulse.
// Optional feature macro: DEMUX_BROADCAST_EN adds in_bcast; a broadcast head
// is offered to every consumer still in the pending mask and pops once all
// have accepted.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_valid / in_ready   : producer handshake
//   in_data, in_select    : payload and destination index
//   in_bcast              : broadcast request (DEMUX_BROADCAST_EN only)
//   out_data              : head payload, 0 when empty
//   out_valid / out_ready : per-consumer handshake
//   err_drop              : head discarded for out-of-range select
// -----------------------------------------------------------------------------
module demux32_buffered
    import demux32_buffered_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SEL_BITS = DEF_SEL_BITS,
    parameter int NUM_DEST = DEF_NUM_DEST
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_BITS-1:0] in_select,
`ifdef DEMUX_BROADCAST_EN
    input  logic                in_bcast,
`endif
    output logic [WIDTH-1:0]    out_data,
    output logic [NUM_DEST-1:0] out_valid,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic                err_drop
);

`ifdef DEMUX_BROADCAST_EN
    localparam int HAS_BCAST = 1;
    localparam int BCAST_OFS = bcast_ofs(WIDTH, SEL_BITS);
`else
    localparam int HAS_BCAST = 0;
`endif
    localparam int DATA_OFS = data_ofs(SEL_BITS);
    localparam int ENTRY_W  = entry_width(WIDTH, SEL_BITS, HAS_BCAST);

    localparam logic [SEL_BITS:0] NUM_DEST_L = (SEL_BITS+1)'(NUM_DEST);

    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                head_vld_p1;
    logic [WIDTH-1:0]    head_data;
    logic [SEL_BITS-1:0] head_sel;
    logic                head_in_range;
    logic [NUM_DEST-1:0] uni_valid;
    logic                uni_pop;
    logic                push;
    logic                pop;

    always_comb begin
        push_entry = '0;
        push_entry[SEL_OFS +: SEL_BITS] = in_select;
        push_entry[DATA_OFS +: WIDTH]   = in_data;
`ifdef DEMUX_BROADCAST_EN
        push_entry[BCAST_OFS] = in_bcast;
`endif
    end

    assign push = in_valid & in_ready;

    demux32_buffered_fifo2 #(
        .ENTRY_W    (ENTRY_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .not_full   (in_ready),
        .head_valid (head_vld_p1),
        .head_entry (head_entry)
    );

    // ---- head stage: everything below depends only on registered queue state
    assign head_data     = head_entry[DATA_OFS +: WIDTH];
    assign head_sel      = head_entry[SEL_OFS +: SEL_BITS];
    assign head_in_range = ({1'b0, head_sel} < NUM_DEST_L);
    assign out_data      = head_vld_p1 ? head_data : '0;

    always_comb begin
        uni_valid = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            uni_valid[k] = head_vld_p1 & (head_sel == SEL_BITS'(k));
        end
    end

    // Out-of-range heads are dropped immediately rather than stalling the queue.
    assign uni_pop = head_vld_p1 & (~head_in_range | (|(uni_valid & out_ready)));

`ifdef DEMUX_BROADCAST_EN
    logic                head_bcast;
    logic [NUM_DEST-1:0] pend_mask;
    logic [NUM_DEST-1:0] mask_left;

    assign head_bcast = head_entry[BCAST_OFS];
    assign mask_left  = pend_mask & ~out_ready;

    always_comb begin
        out_valid = uni_valid;
        err_drop  = head_vld_p1 & ~head_in_range;
        pop       = uni_pop;
        if (head_vld_p1 && head_bcast) begin
            out_valid = pend_mask;
            err_drop  = 1'b0;
            pop       = (mask_left == '0);
        end
    end

    // Consumers that have taken the broadcast word drop out of the mask;
    // the mask reloads as the entry leaves so the next broadcast starts full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_mask <= '1;
        end else if (head_vld_p1 && head_bcast) begin
            pend_mask <= (mask_left == '0) ? '1 : mask_left;
        end
    end
`else
    assign out_valid = uni_valid;
    assign err_drop  = head_vld_p1 & ~head_in_range;
    assign pop       = uni_pop;
`endif

endmodule

// File: doc/demux32_buffered.md
# demux32_buffered

Registered 1-to-N write distributor: accepts one {data, destination-select} word per handshake from a single producer, buffers it in a two-entry queue, and delivers it over a shared data bus to exactly one of up to 32 consumers via per-destination valid/ready. It is the fan-out counterpart of the tristate/decoder selectors in the processor datapath. Typical uses are writeback to register-file ports, peripheral registers, or mole-display latches.

## Interface
- `WIDTH`, 32: data word width.
- `SEL_BITS`, 5: destination select width.
- `NUM_DEST`, 32: number of consumers; must be ≤ 2**SEL_BITS.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: producer offers a word.
- `in_ready` out 1: buffer can accept. Transfer occurs when `in_valid & in_ready`.
- `in_data` in WIDTH: payload.
- `in_select` in SEL_BITS: destination index.
- `in_bcast` in 1: broadcast request. Present only with `DEMUX_BROADCAST_EN`.
- `out_data` out WIDTH: shared payload bus driven to all consumers. Actively driven, never high-Z.
- `out_valid` out NUM_DEST: one-hot (zero-or-one-hot) valid per consumer.
- `out_ready` in NUM_DEST: per-consumer accept.
- `err_drop` out 1: one-cycle pulse when a head entry is discarded for an out-of-range select.

## Operation
- Queue: 2 entries, each {data, select, bcast}, with a 2-bit occupancy count (0..2). The head entry is presented on the outputs.
- `in_ready` = (count < 2). No push when count == 2, even if a pop happens the same cycle.
- Head decode: `out_valid[k]` = head_valid & (select == k) & (k < NUM_DEST). `out_data` = head data, or 0 when the queue is empty.
- Pop: when `out_valid[k] & out_ready[k]` for the selected k, the head is removed at the clock edge and the next entry becomes head in the following cycle.
- Out-of-range (`select ≥ NUM_DEST`): no `out_valid` is raised. The head is popped in the cycle it becomes head, and `err_drop` is asserted for exactly that cycle.
- Simultaneous push and pop: count unchanged and order preserved. Push into an empty queue makes the entry head at T+1.
- `out_ready` on non-selected destinations is ignored.
- Reset mid-transfer: all queued entries are discarded with no delivery.

## Timing
- Reset values: count 0, `in_ready` 1, `out_valid` all 0, `out_data` 0, `err_drop` 0, broadcast pending mask all 1s.
- Latency: accepted at edge T, visible on `out_valid`/`out_data` from T+1 (minimum 1 cycle).
- Throughput: 1 word/cycle sustained when the consumer holds ready high (count stays at 1).
- `out_valid` and `err_drop` depend only on registered state. There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.
- Once asserted, `out_valid[k]` and `out_data` hold stable until the handshake completes.

## Configuration
- `DEMUX_BROADCAST_EN` defined:
  - The `in_bcast` port and its queue field exist.
  - A broadcast head raises `out_valid[k]` for every k < NUM_DEST whose pending-mask bit is set, and clears bit k on each handshake.
  - The head pops when the mask would become empty. The mask then reloads to all 1s.
  - Several consumers may accept in the same cycle. Select is ignored for broadcast, and `err_drop` never fires for broadcast.
- Not defined: the port, queue field, and mask are absent, and only unicast behaviour exists.

## Structure
- Shared header (`demux_defs.vh`):
  - Default `WIDTH`, `SEL_BITS`, and `NUM_DEST` constants.
  - Queue depth constant (2).
  - Entry field offsets used for the packed entry vector.
- Sub-module `demux_fifo2`: two-entry storage with count, push/pop, and head outputs, reset with `reset_n`.
- Top level: destination decode (reuse the existing 5-to-32 decoder for SEL_BITS = 5), pop logic, error pulse, and broadcast mask.

## Test plan
- Reset, then push data=0xDEADBEEF, select=3 with `out_ready` = 0 → `out_valid` = 0x00000008 from T+1 and holds; raise `out_ready[3]` → popped, `out_valid` = 0 next cycle.
- Hold `out_ready[7]` high and stream 0,1,2,3 to select 7 back-to-back → one delivery per cycle, in order, `in_ready` never drops.
- All `out_ready` = 0, push 3 words → `in_ready` falls after the 2nd accept, the 3rd is held off, and it is accepted the cycle after the first pop.
- NUM_DEST = 20, push select=25, then select=2 → `err_drop` pulses once at T+1, no `out_valid` for the first word, and the second word is delivered to index 2.
- `DEMUX_BROADCAST_EN`, NUM_DEST = 4, bcast word 0xA5: ready on 0 and 2, then on 1 and 3 → `out_valid` goes 0xF → 0xA → 0, and the entry pops after the second handshake.
- Assert `reset_n` = 0 with 2 entries queued → outputs return to reset values immediately (asynchronously), and no delivery occurs after release.
